spi_rx_axis_packer: RTL and testbench

SPI_RX_AXIS_PACKER -- requirements
Module: spi_rx_axis_packer

---
 rtl/spi_rx_axis_packer.sv | 140 ++++++++++++++
 tb/tb_spi_rx_axis_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_axis_packer.sv
// Packs SPI receive words into AXI-Stream beats. Words fill lanes of an assembly
// buffer; a full buffer is held until either the next word arrives (beat goes out
// with tlast=0) or frame_end closes the frame (beat goes out with tlast=1).
module spi_rx_axis_packer #(
  parameter int unsigned SPI_TL        = 8,
  parameter int unsigned AXIS_BITWIDTH = 256,
  parameter int unsigned AXIS_ENDIAN   = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  // SPI word input
  input  logic [SPI_TL-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       frame_end,
  // AXI-Stream master
  output logic                       axis_m_tvalid,
  input  logic                       axis_m_tready,
  output logic [AXIS_BITWIDTH-1:0]   axis_m_tdata,
  output logic                       axis_m_tlast,
  output logic [AXIS_BITWIDTH/8-1:0] axis_m_tkeep,
  output logic [AXIS_BITWIDTH/8-1:0] axis_m_tstrb,
  // Completed frame counter
  output logic [15:0]                frame_cnt
);

  localparam int unsigned N  = AXIS_BITWIDTH / SPI_TL;
  localparam int unsigned KW = AXIS_BITWIDTH / 8;
  localparam int unsigned KB = SPI_TL / 8;
  localparam int unsigned IW = $clog2(N + 1);

  // Elaboration-time parameter sanity
  if (!(SPI_TL == 8 || SPI_TL == 16 || SPI_TL == 32)) begin : g_bad_spi_tl
    $error("SPI_TL must be 8, 16 or 32");
  end
  if ((AXIS_BITWIDTH % SPI_TL) != 0 || AXIS_BITWIDTH < SPI_TL) begin : g_bad_width
    $error("AXIS_BITWIDTH must be a non-zero multiple of SPI_TL");
  end
  if (AXIS_ENDIAN > 1) begin : g_bad_endian
    $error("AXIS_ENDIAN must be 0 or 1");
  end

  // Assembly buffer state; idx counts filled lanes (0 = empty, N = held)
  logic [IW-1:0]            idx_q, idx_d;
  logic [AXIS_BITWIDTH-1:0] asm_data_q, asm_data_d;
  logic [KW-1:0]            asm_keep_q, asm_keep_d;
  logic                     flush_pend_q;

  logic held;
  logic slot_free;
  logic accept;
  logic do_flush;
  logic do_push;
  logic set_pend;

  assign held      = (idx_q == IW'(N));
  assign slot_free = !axis_m_tvalid || axis_m_tready;

  // Ready is held low during reset, on frame_end and while a flush waits for the slot
  assign s_ready = aresetn && !frame_end && !flush_pend_q && (!held || slot_free);
  assign accept  = s_valid && s_ready;

  // Flush closes a non-empty frame; accept is impossible in the same cycle
  assign do_flush = slot_free && (flush_pend_q || (frame_end && idx_q != '0));
  assign set_pend = !slot_free && !flush_pend_q && frame_end && idx_q != '0;
  // A held beat leaves only when the next word arrives
  assign do_push  = accept && held;

  assign axis_m_tstrb = axis_m_tkeep;

  // Next-state of the assembly buffer: clear on flush, start fresh on push, else fill a lane
  always_comb begin
    logic [IW-1:0] wr_idx;
    int            lane;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    idx_d      = idx_q;
    wr_idx     = held ? '0 : idx_q;
    lane       = (AXIS_ENDIAN != 0) ? (int'(N) - 1 - int'(wr_idx)) : int'(wr_idx);
    if (do_flush) begin
      asm_data_d = '0;
      asm_keep_d = '0;
      idx_d      = '0;
    end else if (accept) begin
      if (held) begin
        asm_data_d = '0;
        asm_keep_d = '0;
      end
      asm_data_d[lane*SPI_TL +: SPI_TL] = s_data;
      asm_keep_d[lane*KB +: KB]         = '1;
      idx_d                             = wr_idx + IW'(1);
    end
  end

  // Assembly buffer and pending-flush registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      asm_data_q   <= '0;
      asm_keep_q   <= '0;
      idx_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      idx_q      <= idx_d;
      if (do_flush) begin
        flush_pend_q <= 1'b0;
      end else if (set_pend) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  // Output register: loads on push or flush, otherwise holds until handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tkeep  <= '0;
      axis_m_tlast  <= 1'b0;
    end else if (do_flush || do_push) begin
      axis_m_tvalid <= 1'b1;
      axis_m_tdata  <= asm_data_q;
      axis_m_tkeep  <= asm_keep_q;
      axis_m_tlast  <= do_flush;
    end else if (axis_m_tready) begin
      axis_m_tvalid <= 1'b0;
    end
  end

  // Count frames as their last beat is handed off
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= '0;
    end else if (axis_m_tvalid && axis_m_tready && axis_m_tlast) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_spi_rx_axis_packer.sv
// Directed bench for spi_rx_axis_packer: little-endian instance plus a big-endian
// instance sharing the same stimulus.
module tb_spi_rx_axis_packer;

  localparam int W  = 256;
  localparam int KW = W / 8;

  logic          clk;
  logic          rstn;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          frame_end;
  logic          tready;

  logic          s_ready, tvalid, tlast;
  logic [W-1:0]  tdata;
  logic [KW-1:0] tkeep, tstrb;
  logic [15:0]   frame_cnt;

  logic          be_s_ready, be_tvalid, be_tlast;
  logic [W-1:0]  be_tdata;
  logic [KW-1:0] be_tkeep, be_tstrb;
  logic [15:0]   be_frame_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  spi_rx_axis_packer #(.SPI_TL(8), .AXIS_BITWIDTH(W), .AXIS_ENDIAN(0)) u_le (
    .aclk          (clk),
    .aresetn       (rstn),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .frame_end     (frame_end),
    .axis_m_tvalid (tvalid),
    .axis_m_tready (tready),
    .axis_m_tdata  (tdata),
    .axis_m_tlast  (tlast),
    .axis_m_tkeep  (tkeep),
    .axis_m_tstrb  (tstrb),
    .frame_cnt     (frame_cnt)
  );

  spi_rx_axis_packer #(.SPI_TL(8), .AXIS_BITWIDTH(W), .AXIS_ENDIAN(1)) u_be (
    .aclk          (clk),
    .aresetn       (rstn),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (be_s_ready),
    .frame_end     (frame_end),
    .axis_m_tvalid (be_tvalid),
    .axis_m_tready (tready),
    .axis_m_tdata  (be_tdata),
    .axis_m_tlast  (be_tlast),
    .axis_m_tkeep  (be_tkeep),
    .axis_m_tstrb  (be_tstrb),
    .frame_cnt     (be_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, waiting (bounded) for s_ready; returns at posedge+1
  task automatic send_word(input logic [7:0] b);
    logic ok;
    ok      = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL send_word timeout: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; frame_end = 1'b0; tready = 1'b0;
    #3;
    chk_cnt++;
    if ({tvalid, tlast, tkeep, tstrb, frame_cnt, s_ready} !== '0 || tdata !== '0)
      $display("FAIL reset_outputs: tvalid=%b tkeep=%h frame_cnt=%0d s_ready=%b required all 0",
               tvalid, tkeep, frame_cnt, s_ready);
    else pass_cnt++;
    #10 rstn = 1'b1;
    tick();
    chk_cnt++;
    if (s_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", s_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_le();
    logic [W-1:0] exp;
    tready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp[k*8 +: 8] = 8'(k);
      send_word(8'(k));
    end
    chk_cnt++;
    if (tvalid !== 1'b0) $display("FAIL full_held_no_beat: tvalid=%b required 0", tvalid);
    else pass_cnt++;
    pulse_frame_end();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tkeep !== 32'hFFFF_FFFF || tdata !== exp)
      $display("FAIL full_beat: tvalid=%b tlast=%b tkeep=%h tdata=%h required 1 1 ffffffff %h",
               tvalid, tlast, tkeep, tdata, exp);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (frame_cnt !== 16'd1 || tvalid !== 1'b0)
      $display("FAIL full_frame_cnt: frame_cnt=%0d tvalid=%b required 1 0", frame_cnt, tvalid);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    logic [W-1:0] exp_le, exp_be;
    exp_le = '0; exp_le[23:0]    = 24'hCCBBAA;
    exp_be = '0; exp_be[255:232] = 24'hAABBCC;
    send_word(8'hAA);
    send_word(8'hBB);
    send_word(8'hCC);
    pulse_frame_end();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tkeep !== 32'h0000_0007 || tdata !== exp_le)
      $display("FAIL partial_le: tlast=%b tkeep=%h tdata=%h required 1 00000007 %h",
               tlast, tkeep, tdata, exp_le);
    else pass_cnt++;
    chk_cnt++;
    if (be_tvalid !== 1'b1 || be_tlast !== 1'b1 || be_tkeep !== 32'hE000_0000 ||
        be_tdata !== exp_be)
      $display("FAIL partial_be: tlast=%b tkeep=%h tdata=%h required 1 e0000000 %h",
               be_tlast, be_tkeep, be_tdata, exp_be);
    else pass_cnt++;
    chk_cnt++;
    if (tstrb !== tkeep || be_tstrb !== be_tkeep)
      $display("FAIL tstrb_eq_tkeep: le %h/%h be %h/%h required equal",
               tstrb, tkeep, be_tstrb, be_tkeep);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (frame_cnt !== 16'd2) $display("FAIL partial_frame_cnt: got %0d required 2", frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp1, exp2;
    exp2   = '0;
    tready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 32) exp1[k*8 +: 8] = 8'(8'h40 + k);
      else        exp2[(k-32)*8 +: 8] = 8'(8'h40 + k);
      send_word(8'(8'h40 + k));
    end
    for (int c = 0; c < 3; c++) tick();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b0 || tkeep !== '1 || tdata !== exp1)
      $display("FAIL bp_beat1_stable: tvalid=%b tlast=%b tkeep=%h required 1 0 ffffffff",
               tvalid, tlast, tkeep);
    else pass_cnt++;
    pulse_frame_end();
    #1;
    chk_cnt++;
    if (s_ready !== 1'b0) $display("FAIL bp_flush_pend_ready: got %b required 0", s_ready);
    else pass_cnt++;
    tready = 1'b1;
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b0 || tdata !== exp1)
      $display("FAIL bp_beat1_out: tvalid=%b tlast=%b required 1 0", tvalid, tlast);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tkeep !== 32'h0000_00FF || tdata !== exp2)
      $display("FAIL bp_beat2: tvalid=%b tlast=%b tkeep=%h tdata=%h required 1 1 000000ff %h",
               tvalid, tlast, tkeep, tdata, exp2);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (frame_cnt !== 16'd3 || tvalid !== 1'b0)
      $display("FAIL bp_frame_cnt: frame_cnt=%0d tvalid=%b required 3 0", frame_cnt, tvalid);
    else pass_cnt++;
  endtask

  task automatic test_empty_collision();
    pulse_frame_end();
    tick();
    chk_cnt++;
    if (tvalid !== 1'b0 || frame_cnt !== 16'd3)
      $display("FAIL empty_frame: tvalid=%b frame_cnt=%0d required 0 3", tvalid, frame_cnt);
    else pass_cnt++;
    send_word(8'h11);
    // frame_end and a new word in the same cycle
    frame_end = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'h22;
    #1;
    chk_cnt++;
    if (s_ready !== 1'b0) $display("FAIL collision_ready: got %b required 0", s_ready);
    else pass_cnt++;
    tick();
    frame_end = 1'b0;
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tkeep !== 32'h1 || tdata[7:0] !== 8'h11)
      $display("FAIL collision_flush: tkeep=%h byte0=%h required 00000001 11",
               tkeep, tdata[7:0]);
    else pass_cnt++;
    tick();  // word 0x22 accepted here
    s_valid = 1'b0;
    pulse_frame_end();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tkeep !== 32'h1 || tdata !== W'(8'h22))
      $display("FAIL collision_next_frame: tkeep=%h tdata=%h required 00000001 22",
               tkeep, tdata);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (frame_cnt !== 16'd5) $display("FAIL collision_frame_cnt: got %0d required 5", frame_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    tready = 1'b1;
    t0 = $time;
    for (int k = 0; k < 64; k++) send_word(8'(k ^ 8'h5C));
    t1 = $time;
    chk_cnt++;
    if (t1 - t0 != 640) $display("FAIL b2b_rate: took %0d ns required 640", t1 - t0);
    else pass_cnt++;
    pulse_frame_end();
    chk_cnt++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata[7:0] !== 8'(32 ^ 8'h5C))
      $display("FAIL b2b_last_beat: tlast=%b byte0=%h required 1 %h", tlast, tdata[7:0],
               8'(32 ^ 8'h5C));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    tready = 1'b0;
    for (int k = 0; k < 37; k++) send_word(8'(k));
    #1 rstn = 1'b0;
    #1;
    chk_cnt++;
    if (tvalid !== 1'b0 || tkeep !== '0 || frame_cnt !== '0 || s_ready !== 1'b0)
      $display("FAIL reset_async: tvalid=%b tkeep=%h frame_cnt=%0d s_ready=%b required 0",
               tvalid, tkeep, frame_cnt, s_ready);
    else pass_cnt++;
    #1 rstn = 1'b1;
    tick();
    tready = 1'b1;
    send_word(8'h01);
    send_word(8'h02);
    pulse_frame_end();
    chk_cnt++;
    if (tvalid !== 1'b1 || tkeep !== 32'h3 || tdata !== W'(16'h0201))
      $display("FAIL reset_next_frame: tkeep=%h tdata=%h required 00000003 0201", tkeep, tdata);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (frame_cnt !== 16'd1) $display("FAIL reset_frame_cnt: got %0d required 1", frame_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_le();
    test_partial();
    test_backpressure();
    test_empty_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
